osd_mam_wb_burst_if: RTL

//  Wishbone B3 master that turns MAM req/write/read streams into classic or incrementing-burst bus cycles.

---
 rtl/osd_mam_wb_burst_if.sv | 123 ++++++++++++
 1 files changed

// File: rtl/osd_mam_wb_burst_if.sv
// osd_mam_wb_burst_if: Wishbone B3 master turning MAM request/data streams into classic or segmented incrementing bursts
module osd_mam_wb_burst_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int MAX_BURST  = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_rw,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic                    req_burst,
  input  logic [13:0]             req_beats,
  input  logic                    write_valid,
  input  logic [DATA_WIDTH-1:0]   write_data,
  input  logic [DATA_WIDTH/8-1:0] write_strb,
  output logic                    write_ready,
  output logic                    read_valid,
  output logic [DATA_WIDTH-1:0]   read_data,
  input  logic                    read_ready,
  output logic                    cyc_o,
  output logic                    stb_o,
  output logic                    we_o,
  output logic [ADDR_WIDTH-1:0]   addr_o,
  output logic [DATA_WIDTH-1:0]   dat_o,
  output logic [DATA_WIDTH/8-1:0] sel_o,
  output logic [2:0]              cti_o,
  output logic [1:0]              bte_o,
  input  logic                    ack_i,
  input  logic                    err_i,
  input  logic [DATA_WIDTH-1:0]   dat_i,
  output logic                    err_o
);
  localparam int SW = DATA_WIDTH / 8;
  typedef enum logic [1:0] {IDLE, WRITE, READ, GAP} state_t;
  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                    rw_q, rw_d;
  logic                    bst_q, bst_d;
  logic [13:0]             rem_q, rem_d;
  logic [8:0]              seg_q, seg_d;
  logic                    err_q, err_d;
  logic                    buf_full_q, buf_full_d;
  logic [DATA_WIDTH-1:0]   buf_q, buf_d;
  logic                    active, last, t, ld;
  // state, address/beat counters and the one-entry read skid buffer
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      rw_q       <= 1'b0;
      bst_q      <= 1'b0;
      rem_q      <= '0;
      seg_q      <= '0;
      err_q      <= 1'b0;
      buf_full_q <= 1'b0;
      buf_q      <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      rw_q       <= rw_d;
      bst_q      <= bst_d;
      rem_q      <= rem_d;
      seg_q      <= seg_d;
      err_q      <= err_d;
      buf_full_q <= buf_full_d;
      buf_q      <= buf_d;
    end
  // bus outputs, beat termination and next-state; counters only move on a terminated beat so cti holds through wait states
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    rw_d        = rw_q;
    bst_d       = bst_q;
    rem_d       = rem_q;
    seg_d       = seg_q;
    err_d       = err_q;
    active      = state_q == WRITE || state_q == READ;
    last        = rem_q == 14'd1 || seg_q == 9'(MAX_BURST - 1);
    cyc_o       = active;
    we_o        = state_q == WRITE;
    stb_o       = state_q == WRITE ? write_valid :
                  state_q == READ  ? rem_q != '0 && (!buf_full_q || read_ready) : 1'b0;
    addr_o      = active ? addr_q : '0;
    dat_o       = state_q == WRITE ? write_data : '0;
    sel_o       = state_q == WRITE ? write_strb : state_q == READ ? {SW{1'b1}} : '0;
    cti_o       = !active || !bst_q ? 3'b000 : last ? 3'b111 : 3'b010;
    bte_o       = 2'b00;
    t           = stb_o && (ack_i || err_i);
    write_ready = we_o && t;
    ld          = t && state_q == READ;
    buf_full_d  = ld || (buf_full_q && !read_ready);
    buf_d       = ld ? dat_i : buf_q;
    read_valid  = buf_full_q;
    read_data   = buf_q;
    req_ready   = state_q == IDLE && !rst_i;
    err_o       = err_q;
    if (state_q == IDLE && req_valid) begin
      addr_d  = req_addr;
      rw_d    = req_rw;
      bst_d   = req_burst;
      rem_d   = !req_burst || req_beats == '0 ? 14'd1 : req_beats;
      seg_d   = '0;
      err_d   = 1'b0;
      state_d = req_rw ? WRITE : READ;
    end
    if (t) begin
      addr_d = addr_q + ADDR_WIDTH'(SW);
      rem_d  = rem_q - 14'd1;
      seg_d  = seg_q + 9'd1;
      err_d  = err_q || err_i;
      if (!bst_q || last)
        state_d = rem_d != '0 ? GAP : state_q == WRITE ? IDLE : READ;
    end
    if (state_q == READ && rem_d == '0 && !buf_full_d)
      state_d = IDLE;
    if (state_q == GAP) begin
      seg_d   = '0;
      state_d = rw_q ? WRITE : READ;
    end
  end
endmodule
